// File: rtl/morse_pkg.sv
// Shared symbol/state encodings and unit-length constants for the Morse tone sequencer.
package morse_pkg;

  typedef enum logic [1:0] {
    SYM_DOT  = 2'b00,
    SYM_DASH = 2'b01,
    SYM_LGAP = 2'b10,
    SYM_WGAP = 2'b11
  } sym_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TONE  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

  localparam logic [2:0] DOT_UNITS     = 3'd1;
  localparam logic [2:0] DASH_UNITS    = 3'd3;
  localparam logic [2:0] LGAP_UNITS    = 3'd2;
  localparam logic [2:0] WGAP_UNITS    = 3'd6;
  localparam logic [2:0] SYM_GAP_UNITS = 3'd1;

  function automatic logic [2:0] sym_units(input sym_t s);
    logic [2:0] u;
    u = DOT_UNITS;
    case (s)
      SYM_DOT:  u = DOT_UNITS;
      SYM_DASH: u = DASH_UNITS;
      SYM_LGAP: u = LGAP_UNITS;
      SYM_WGAP: u = WGAP_UNITS;
      default:  u = DOT_UNITS;
    endcase
    return u;
  endfunction

  function automatic logic sym_is_tone(input sym_t s);
    return (s == SYM_DOT) || (s == SYM_DASH);
  endfunction

endpackage

// File: rtl/morse_tone_sequencer_if.sv
// Symbol handshake between the message playback logic and the tone sequencer.
interface morse_tone_sequencer_if;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;

  modport master (output sym_in, output sym_valid, input sym_ready);
  modport slave  (input sym_in, input sym_valid, output sym_ready);
endinterface

// File: rtl/morse_tone_sequencer_fifo.sv
// Small synchronous symbol FIFO; exposes the next-cycle occupancy so the parent can register its flags.
module morse_sym_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     cclk,
  input  logic                     rstb,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count_nxt
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge cclk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/morse_tone_sequencer.sv
// Plays queued Morse symbols by sequencing the PWM duty_cycle in whole time units.
module morse_tone_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned CLK_PER_UNIT = 2700000,
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [7:0]  TONE_DUTY    = 8'd128,
  parameter logic [7:0]  TONE_FREQ    = 8'd10
) (
  input  logic                     cclk,
  input  logic                     rstb,
  morse_tone_sequencer_if.slave    sym_bus,
  input  logic                     enable,
  output logic [7:0]               duty_cycle,
  output logic [7:0]               base_frequency,
  output logic                     busy
);

  localparam int unsigned       FAW       = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(CLK_PER_UNIT - 1);

  state_t           state, state_n;
  logic [2:0]       units, units_n;
  logic [CNT_W-1:0] tick_cnt, tick_n;
  logic             push, pop;
  logic [1:0]       fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [FAW:0]     fifo_count_nxt;
  logic             start_ok;
  sym_t             head_sym;

  assign push     = sym_bus.sym_valid && sym_bus.sym_ready && !fifo_full;
  assign head_sym = sym_t'(fifo_rdata);
  assign start_ok = !fifo_empty && enable;

  morse_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .cclk      (cclk),
    .rstb      (rstb),
    .push      (push),
    .wdata     (sym_bus.sym_in),
    .pop       (pop),
    .rdata     (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count_nxt (fifo_count_nxt)
  );

  // The end of a SPACE reloads straight from the FIFO so consecutive symbols share no idle cycle.
  always_comb begin
    state_n = state;
    units_n = units;
    tick_n  = tick_cnt;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        tick_n = '0;
        if (start_ok) begin
          pop     = 1'b1;
          state_n = sym_is_tone(head_sym) ? ST_TONE : ST_SPACE;
          units_n = sym_units(head_sym);
        end
      end
      ST_TONE, ST_SPACE: begin
        if (tick_cnt == TICK_LAST) begin
          tick_n = '0;
          if (units == 3'd1) begin
            if (state == ST_TONE) begin
              state_n = ST_SPACE;
              units_n = SYM_GAP_UNITS;
            end else if (start_ok) begin
              pop     = 1'b1;
              state_n = sym_is_tone(head_sym) ? ST_TONE : ST_SPACE;
              units_n = sym_units(head_sym);
            end else begin
              state_n = ST_IDLE;
              units_n = '0;
            end
          end else begin
            units_n = units - 3'd1;
          end
        end else begin
          tick_n = tick_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        units_n = '0;
        tick_n  = '0;
      end
    endcase
  end

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      state             <= ST_IDLE;
      units             <= '0;
      tick_cnt          <= '0;
      duty_cycle        <= '0;
      base_frequency    <= TONE_FREQ;
      busy              <= 1'b0;
      sym_bus.sym_ready <= 1'b0;
    end else begin
      state             <= state_n;
      units             <= units_n;
      tick_cnt          <= tick_n;
      duty_cycle        <= (state_n == ST_TONE) ? TONE_DUTY : '0;
      base_frequency    <= TONE_FREQ;
      busy              <= (state_n != ST_IDLE) || (fifo_count_nxt != '0);
      sym_bus.sym_ready <= (fifo_count_nxt != (FAW+1)'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_morse_tone_sequencer.sv
// Directed self-checking bench for morse_tone_sequencer with CLK_PER_UNIT=4, FIFO_DEPTH=4.
module tb_morse_tone_sequencer;

  logic       cclk;
  logic       rstb;
  logic       enable;
  logic [7:0] duty_cycle;
  logic [7:0] base_frequency;
  logic       busy;
  int         total = 0;
  int         bad   = 0;

  morse_tone_sequencer_if sif ();

  morse_tone_sequencer #(
    .CLK_PER_UNIT (4),
    .CNT_W        (4),
    .FIFO_DEPTH   (4),
    .TONE_DUTY    (8'd128),
    .TONE_FREQ    (8'd10)
  ) dut (
    .cclk           (cclk),
    .rstb           (rstb),
    .sym_bus        (sif),
    .enable         (enable),
    .duty_cycle     (duty_cycle),
    .base_frequency (base_frequency),
    .busy           (busy)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  task automatic do_reset();
    rstb          = 1'b0;
    enable        = 1'b1;
    sif.sym_valid = 1'b0;
    sif.sym_in    = 2'b00;
    step();
    step();
    rstb = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rstb          = 1'b0;
    enable        = 1'b1;
    sif.sym_valid = 1'b0;
    sif.sym_in    = 2'b00;
    step();
    step();
    step();
    total++; if (duty_cycle !== 8'd0) begin bad++; $display("FAIL reset_duty got=%0d exp=0", duty_cycle); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (sif.sym_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", sif.sym_ready); end
    total++; if (base_frequency !== 8'd10) begin bad++; $display("FAIL reset_freq got=%0d exp=10", base_frequency); end
    rstb = 1'b1;
    step();
    total++; if (sif.sym_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%0b exp=1", sif.sym_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_single_dot();
    logic [7:0] ed;
    logic       eb;
    do_reset();
    for (int i = 0; i <= 9; i++) begin
      sif.sym_valid = (i == 0);
      sif.sym_in    = 2'b00;
      step();
      ed = (i >= 1 && i <= 4) ? 8'd128 : 8'd0;
      eb = (i <= 8);
      total++; if (duty_cycle !== ed) begin bad++; $display("FAIL dot_duty[%0d] got=%0d exp=%0d", i, duty_cycle, ed); end
      total++; if (busy !== eb) begin bad++; $display("FAIL dot_busy[%0d] got=%0b exp=%0b", i, busy, eb); end
    end
    sif.sym_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [3];
    logic [7:0] ed;
    logic       eb;
    seq[0] = 2'b01;
    seq[1] = 2'b10;
    seq[2] = 2'b00;
    do_reset();
    for (int i = 0; i <= 33; i++) begin
      sif.sym_valid = (i < 3);
      sif.sym_in    = (i < 3) ? seq[i] : 2'b00;
      step();
      ed = ((i >= 1 && i <= 12) || (i >= 25 && i <= 28)) ? 8'd128 : 8'd0;
      eb = (i <= 32);
      total++; if (duty_cycle !== ed) begin bad++; $display("FAIL b2b_duty[%0d] got=%0d exp=%0d", i, duty_cycle, ed); end
      total++; if (busy !== eb) begin bad++; $display("FAIL b2b_busy[%0d] got=%0b exp=%0b", i, busy, eb); end
    end
    sif.sym_valid = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [1:0] seq [6];
    int         exp_len [6];
    int         runs [8];
    int         nr;
    int         run;
    int         j;
    logic       acc;
    logic       done;
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b01;
    seq[3] = 2'b00; seq[4] = 2'b01; seq[5] = 2'b00;
    exp_len[0] = 4;  exp_len[1] = 12; exp_len[2] = 12;
    exp_len[3] = 4;  exp_len[4] = 12; exp_len[5] = 4;
    nr = 0; run = 0; j = 0; done = 1'b0;
    for (int k = 0; k < 8; k++) runs[k] = 0;
    do_reset();
    for (int c = 0; c < 150 && !done; c++) begin
      sif.sym_valid = (j < 6);
      sif.sym_in    = (j < 6) ? seq[j] : 2'b00;
      acc = sif.sym_valid && sif.sym_ready;
      step();
      if (acc) j++;
      if (c == 3) begin
        total++; if (sif.sym_ready !== 1'b1) begin bad++; $display("FAIL full_ready_c3 got=%0b exp=1", sif.sym_ready); end
      end
      if (c == 4) begin
        total++; if (sif.sym_ready !== 1'b0) begin bad++; $display("FAIL full_ready_c4 got=%0b exp=0", sif.sym_ready); end
        total++; if (j !== 5) begin bad++; $display("FAIL full_accepted_c4 got=%0d exp=5", j); end
      end
      if (duty_cycle == 8'd128) run++;
      else if (run > 0) begin
        if (nr < 8) runs[nr] = run;
        nr++;
        run = 0;
      end
      if (j == 6 && !busy && run == 0) done = 1'b1;
    end
    sif.sym_valid = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL full_timeout got=%0b exp=1", done); end
    total++; if (j !== 6) begin bad++; $display("FAIL full_accepted got=%0d exp=6", j); end
    total++; if (nr !== 6) begin bad++; $display("FAIL full_run_count got=%0d exp=6", nr); end
    for (int k = 0; k < 6; k++) begin
      total++; if (runs[k] !== exp_len[k]) begin bad++; $display("FAIL full_run[%0d] got=%0d exp=%0d", k, runs[k], exp_len[k]); end
    end
  endtask

  task automatic test_enable_hold();
    logic [7:0] ed;
    logic       eb;
    do_reset();
    for (int i = 0; i <= 34; i++) begin
      sif.sym_valid = (i < 3);
      sif.sym_in    = 2'b00;
      if (i == 11) enable = 1'b0;
      if (i == 25) enable = 1'b1;
      step();
      ed = ((i >= 1 && i <= 4) || (i >= 9 && i <= 12) || (i >= 25 && i <= 28)) ? 8'd128 : 8'd0;
      eb = (i <= 32);
      total++; if (duty_cycle !== ed) begin bad++; $display("FAIL en_duty[%0d] got=%0d exp=%0d", i, duty_cycle, ed); end
      total++; if (busy !== eb) begin bad++; $display("FAIL en_busy[%0d] got=%0b exp=%0b", i, busy, eb); end
    end
    sif.sym_valid = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [1:0] seq [3];
    logic [7:0] ed;
    logic       er;
    seq[0] = 2'b01;
    seq[1] = 2'b00;
    seq[2] = 2'b00;
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      sif.sym_valid = (i < 3);
      sif.sym_in    = (i < 3) ? seq[i] : 2'b00;
      if (i == 6) rstb = 1'b0;
      if (i == 8) rstb = 1'b1;
      step();
      ed = (i >= 1 && i <= 5) ? 8'd128 : 8'd0;
      er = !(i == 6 || i == 7);
      total++; if (duty_cycle !== ed) begin bad++; $display("FAIL rst_duty[%0d] got=%0d exp=%0d", i, duty_cycle, ed); end
      if (i >= 6) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy[%0d] got=%0b exp=0", i, busy); end
        total++; if (sif.sym_ready !== er) begin bad++; $display("FAIL rst_ready[%0d] got=%0b exp=%0b", i, sif.sym_ready, er); end
      end
    end
    sif.sym_valid = 1'b0;
    rstb = 1'b1;
  endtask

  task automatic test_word_gap();
    logic eb;
    do_reset();
    for (int i = 0; i <= 26; i++) begin
      sif.sym_valid = (i == 0);
      sif.sym_in    = 2'b11;
      step();
      eb = (i <= 24);
      total++; if (duty_cycle !== 8'd0) begin bad++; $display("FAIL wgap_duty[%0d] got=%0d exp=0", i, duty_cycle); end
      total++; if (busy !== eb) begin bad++; $display("FAIL wgap_busy[%0d] got=%0b exp=%0b", i, busy, eb); end
      total++; if (base_frequency !== 8'd10) begin bad++; $display("FAIL wgap_freq[%0d] got=%0d exp=10", i, base_frequency); end
    end
    sif.sym_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_dot();
    test_back_to_back();
    test_fifo_full();
    test_enable_hold();
    test_reset_mid();
    test_word_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_tone_sequencer.md
Name: morse_tone_sequencer

Overview:
Plays a queue of Morse symbols on the buzzer by driving the duty_cycle and base_frequency inputs of the shared PWM tone generator. A small symbol FIFO decouples the message/keyer logic from the audio timing. A unit-time counter and an FSM turn each dot, dash or gap into exact on and off intervals. The block sits between the message playback logic (upstream) and the PWM module (downstream).

Parameters:
CLK_PER_UNIT, 2700000, cclk cycles per Morse time unit (100 ms at 27 MHz); must be >= 2
CNT_W, 24, width of the tick counter; must satisfy 2^CNT_W > CLK_PER_UNIT
FIFO_DEPTH, 4, symbol FIFO entries; power of 2, >= 2
TONE_DUTY, 8'd128, duty_cycle value while the tone is on
TONE_FREQ, 8'd10, base_frequency value presented to the PWM

Ports:
cclk  in  1  clock
rstb  in  1  reset; synchronous, active-low; clock cclk
sym_in  in  2  symbol: 00 dot, 01 dash, 10 letter gap, 11 word gap
sym_valid  in  1  sym_in is valid
sym_ready  out  1  FIFO can accept a symbol; a push happens when sym_valid && sym_ready
enable  in  1  playback enable; when low, no new symbol is started
duty_cycle  out  8  to PWM duty_cycle; TONE_DUTY while on, 0 otherwise
base_frequency  out  8  to PWM base_frequency
busy  out  1  high when FSM is not IDLE or FIFO is not empty

Behaviour:
- Reset (rstb low at a cclk edge): FIFO empty, FSM IDLE, tick and unit counters 0, duty_cycle=0, base_frequency=TONE_FREQ, busy=0, sym_ready=0. sym_ready becomes 1 on the first edge with rstb high.
- Reset mid-symbol: abort immediately, duty_cycle=0 at that edge, queued symbols discarded.
- All outputs are registered.
- FIFO:
  - sym_ready = !full.
  - Push and pop in the same cycle are both honoured when not full.
  - Push while full cannot occur (sym_ready=0), so no overflow.
- Symbol timing, in units:
  - dot: 1 on + 1 off.
  - dash: 3 on + 1 off.
  - letter gap: 2 off.
  - word gap: 6 off.
  - After a preceding symbol's trailing gap, this gives standard 3-unit and 7-unit spacing.
- FSM states: IDLE, TONE, SPACE.
  - IDLE: if FIFO not empty and enable=1, pop. A dot/dash goes to TONE with units=1 or 3. A gap goes to SPACE with units=2 or 6.
  - TONE: duty_cycle=TONE_DUTY. tick_cnt counts 0..CLK_PER_UNIT-1. On wrap, units decrements. On the wrap of the last unit, go to SPACE with units=1.
  - SPACE: duty_cycle=0, counting the same way. At the end of the last unit:
    - if FIFO not empty and enable=1, pop and load the next symbol directly (no IDLE cycle);
    - otherwise go to IDLE.
- Latency: push at edge N into an empty FIFO while IDLE and enabled. Pop occurs at edge N+1, and duty_cycle=TONE_DUTY from edge N+1 (one-cycle registered pop-to-output).
- Tone high time is exactly units*CLK_PER_UNIT cycles. Back-to-back symbols have no extra cycles.
- enable deasserted mid-symbol: the current symbol, including its trailing off time, completes. The FSM then holds in IDLE, with the FIFO contents retained.
- Counters: tick_cnt is CNT_W bits and wraps at CLK_PER_UNIT-1, never at 2^CNT_W. units is 3 bits.
- base_frequency is held constant at TONE_FREQ at all times.

Decomposition:
- Package morse_pkg:
  - symbol encodings SYM_DOT, SYM_DASH, SYM_LGAP, SYM_WGAP;
  - state encodings ST_IDLE, ST_TONE, ST_SPACE;
  - unit-length constants DOT_UNITS=1, DASH_UNITS=3, LGAP_UNITS=2, WGAP_UNITS=6, SYM_GAP_UNITS=1.
- One sub-module, morse_sym_fifo: parameterised synchronous FIFO (width 2, depth FIFO_DEPTH) with push/pop/full/empty.
- FSM and counters live in the top module.

Test Plan (CLK_PER_UNIT=4, FIFO_DEPTH=4):
1. Reset, then push dot at edge N -> duty_cycle=128 for exactly 4 cycles from edge N+1, then 0 for 4 cycles. busy falls 8 cycles after N+1.
2. Push dash, letter gap, dot back-to-back -> duty high 12, low 4+8, high 4, low 4. No idle cycles between symbols.
3. Hold sym_valid with 6 symbols while playback is running -> sym_ready drops after 4 stored. All 6 are played in order, none lost or duplicated.
4. Drop enable during the second of 3 queued dots -> that dot completes (4 on, 4 off). FSM IDLE with 1 symbol retained. Re-raise enable -> the remaining dot plays.
5. Assert rstb=0 midway through a dash -> duty_cycle=0 at that edge, busy=0, FIFO empty, sym_ready=0, then 1 the cycle after release.
6. Word gap alone -> duty_cycle stays 0 and busy high for 24 cycles. base_frequency stays 10 throughout.
